// File: rtl/riscv_timer_pkg.sv
// Shared definitions for the memory-mapped machine timer: register offsets,
// CTRL bit positions, bus constants and the byte-mask merge helper.
package riscv_timer_pkg;

  localparam int          DBUS_MASK       = 4;
  localparam logic [31:0] TIMER_BASE_ADDR = 32'h0200_0000;
  localparam logic [63:0] TIMER_CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam int          TIMER_INT_IDX   = 0;

  localparam int CTRL_EN_BIT = 0;
  localparam int CTRL_IE_BIT = 1;

  // Word index taken from addr[4:2]
  typedef enum logic [2:0] {
    TIMER_CTRL     = 3'd0,
    TIMER_PRESCALE = 3'd1,
    TIMER_TIME_LO  = 3'd2,
    TIMER_TIME_HI  = 3'd3,
    TIMER_CMP_LO   = 3'd4,
    TIMER_CMP_HI   = 3'd5
  } timer_reg_e;

  function automatic logic [31:0] apply_mask(input logic [31:0]          old_val,
                                             input logic [31:0]          wdata,
                                             input logic [DBUS_MASK-1:0] mask);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < DBUS_MASK; i++) begin
      if (mask[i]) begin
        res[8*i +: 8] = wdata[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_val[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/riscv_timer_prescaler.sv
// Tick generator for the machine timer; only built when TIMER_PRESCALE_EN
// is defined (otherwise the timer ticks directly from CTRL.EN).
`ifdef TIMER_PRESCALE_EN
module timer_prescaler (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] prescale,
  input  logic        clr,
  output logic        tick
);

  logic [15:0] cnt_r;
  logic [15:0] cnt_next_s;

  assign tick = en & (cnt_r == prescale);

  // Counter advances only while enabled; a PRESCALE write restarts it
  always_comb begin
    cnt_next_s = cnt_r;
    if (clr) begin
      cnt_next_s = 16'd0;
    end else if (tick) begin
      cnt_next_s = 16'd0;
    end else if (en) begin
      cnt_next_s = cnt_r + 16'd1;
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= 16'd0;
    end else begin
      cnt_r <= cnt_next_s;
    end
  end

endmodule
`endif

// File: rtl/riscv_timer.sv
// Memory-mapped 64-bit machine timer (mtime/mtimecmp) with a level interrupt.
// Optional feature macro: TIMER_PRESCALE_EN (programmable tick prescaler).
module riscv_timer
  import riscv_timer_pkg::*;
#(
  parameter logic [63:0] CMP_RESET = TIMER_CMP_RESET
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 I_req,
  input  logic                 I_we,
  input  logic [31:0]          I_addr,
  input  logic [31:0]          I_wdata,
  input  logic [DBUS_MASK-1:0] I_mask,
  output logic [31:0]          O_rdata,
  output logic                 O_ready,
  output logic                 O_timer_int
);

  logic [1:0]  ctrl_r;
  logic [1:0]  ctrl_next_s;
  logic [63:0] mtime_r;
  logic [63:0] mtime_next_s;
  logic [63:0] mtimecmp_r;
  logic [63:0] mtimecmp_next_s;
  logic [31:0] hi_shadow_r;
  logic [31:0] hi_shadow_next_s;
  logic        pend_r;
  logic [31:0] pend_rdata_r;
  logic        ready_r;
  logic [31:0] rdata_r;
  logic        int_r;
  logic [31:0] rd_data_s;
  logic        tick_s;
  logic        wr_s;
  logic        rd_s;
  timer_reg_e  reg_sel_s;
  logic        unused_addr_s;

  assign wr_s          = I_req & I_we;
  assign rd_s          = I_req & ~I_we;
  assign reg_sel_s     = timer_reg_e'(I_addr[4:2]);
  assign unused_addr_s = ^{I_addr[31:5], I_addr[1:0]};

`ifdef TIMER_PRESCALE_EN
  logic [15:0] prescale_r;
  logic [15:0] prescale_next_s;
  logic        prescale_wr_s;

  assign prescale_wr_s = wr_s & (reg_sel_s == TIMER_PRESCALE);

  // Byte-masked PRESCALE update
  always_comb begin
    prescale_next_s = prescale_r;
    if (prescale_wr_s) begin
      if (I_mask[0]) begin
        prescale_next_s[7:0] = I_wdata[7:0];
      end else begin
        prescale_next_s[7:0] = prescale_r[7:0];
      end
      if (I_mask[1]) begin
        prescale_next_s[15:8] = I_wdata[15:8];
      end else begin
        prescale_next_s[15:8] = prescale_r[15:8];
      end
    end else begin
      prescale_next_s = prescale_r;
    end
  end

  // PRESCALE register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescale_r <= 16'd0;
    end else begin
      prescale_r <= prescale_next_s;
    end
  end

  timer_prescaler u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (ctrl_r[CTRL_EN_BIT]),
    .prescale (prescale_r),
    .clr      (prescale_wr_s),
    .tick     (tick_s)
  );
`else
  assign tick_s = ctrl_r[CTRL_EN_BIT];
`endif

  // Register writes; an mtime write replaces the tick increment for all 64 bits
  always_comb begin
    ctrl_next_s      = ctrl_r;
    mtimecmp_next_s  = mtimecmp_r;
    hi_shadow_next_s = hi_shadow_r;
    if (tick_s) begin
      mtime_next_s = mtime_r + 64'd1;
    end else begin
      mtime_next_s = mtime_r;
    end
    if (wr_s) begin
      case (reg_sel_s)
        TIMER_CTRL: begin
          if (I_mask[0]) begin
            ctrl_next_s = I_wdata[1:0];
          end else begin
            ctrl_next_s = ctrl_r;
          end
        end
        TIMER_TIME_LO: mtime_next_s = {mtime_r[63:32], apply_mask(mtime_r[31:0], I_wdata, I_mask)};
        TIMER_TIME_HI: mtime_next_s = {apply_mask(mtime_r[63:32], I_wdata, I_mask), mtime_r[31:0]};
        TIMER_CMP_LO:  mtimecmp_next_s = {mtimecmp_r[63:32], apply_mask(mtimecmp_r[31:0], I_wdata, I_mask)};
        TIMER_CMP_HI:  mtimecmp_next_s = {apply_mask(mtimecmp_r[63:32], I_wdata, I_mask), mtimecmp_r[31:0]};
        default:       ctrl_next_s = ctrl_r;
      endcase
    end else if (rd_s && (reg_sel_s == TIMER_TIME_LO)) begin
      hi_shadow_next_s = mtime_r[63:32];
    end else begin
      hi_shadow_next_s = hi_shadow_r;
    end
  end

  // Read mux; MTIME_HI returns the half latched by the last MTIME_LO read
  always_comb begin
    rd_data_s = 32'd0;
    if (rd_s) begin
      case (reg_sel_s)
        TIMER_CTRL:     rd_data_s = {30'd0, ctrl_r};
`ifdef TIMER_PRESCALE_EN
        TIMER_PRESCALE: rd_data_s = {16'd0, prescale_r};
`else
        TIMER_PRESCALE: rd_data_s = 32'd0;
`endif
        TIMER_TIME_LO:  rd_data_s = mtime_r[31:0];
        TIMER_TIME_HI:  rd_data_s = hi_shadow_r;
        TIMER_CMP_LO:   rd_data_s = mtimecmp_r[31:0];
        TIMER_CMP_HI:   rd_data_s = mtimecmp_r[63:32];
        default:        rd_data_s = 32'd0;
      endcase
    end else begin
      rd_data_s = 32'd0;
    end
  end

  // Architectural state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_r      <= 2'd0;
      mtime_r     <= 64'd0;
      mtimecmp_r  <= CMP_RESET;
      hi_shadow_r <= 32'd0;
    end else begin
      ctrl_r      <= ctrl_next_s;
      mtime_r     <= mtime_next_s;
      mtimecmp_r  <= mtimecmp_next_s;
      hi_shadow_r <= hi_shadow_next_s;
    end
  end

  // Two-stage response pipe: capture at the sampling edge, present one edge later
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_r       <= 1'b0;
      pend_rdata_r <= 32'd0;
      ready_r      <= 1'b0;
      rdata_r      <= 32'd0;
    end else begin
      pend_r       <= I_req;
      pend_rdata_r <= rd_data_s;
      ready_r      <= pend_r;
      rdata_r      <= pend_rdata_r;
    end
  end

  // Level interrupt, unsigned 64-bit compare
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      int_r <= 1'b0;
    end else begin
      int_r <= ctrl_r[CTRL_IE_BIT] & (mtime_r >= mtimecmp_r);
    end
  end

  assign O_ready     = ready_r;
  assign O_rdata     = rdata_r;
  assign O_timer_int = int_r;

endmodule

// File: tb/tb_riscv_timer.sv
// Directed, table-driven bench for riscv_timer with hand-written multi-cycle
// sequences for counting, carry/shadow, interrupt, masked-write and reset cases.
module tb_riscv_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        I_req = 1'b0;
  logic        I_we = 1'b0;
  logic [31:0] I_addr = 32'd0;
  logic [31:0] I_wdata = 32'd0;
  logic [3:0]  I_mask = 4'd0;
  logic [31:0] O_rdata;
  logic        O_ready;
  logic        O_timer_int;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [31:0] t_rdata;
  logic        t_ready0, t_ready1, t_int0, t_int1;
  int          t_edge;

  typedef struct {
    logic        we;
    logic [2:0]  off;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[22];

  riscv_timer dut (
    .clk         (clk),
    .rst         (rst),
    .I_req       (I_req),
    .I_we        (I_we),
    .I_addr      (I_addr),
    .I_wdata     (I_wdata),
    .I_mask      (I_mask),
    .O_rdata     (O_rdata),
    .O_ready     (O_ready),
    .O_timer_int (O_timer_int)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    I_req = 1'b0; I_we = 1'b0; I_wdata = 32'd0; I_mask = 4'd0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One request; samples right after the sampling edge N and after edge N+1
  task automatic xact(input logic we, input logic [2:0] off, input logic [31:0] wd, input logic [3:0] mk);
    @(negedge clk);
    I_req = 1'b1; I_we = we; I_addr = 32'h0200_0000 | {27'd0, off, 2'b00}; I_wdata = wd; I_mask = mk;
    @(posedge clk); #1;
    t_edge = cyc; t_ready0 = O_ready; t_int0 = O_timer_int;
    @(negedge clk);
    I_req = 1'b0; I_we = 1'b0; I_wdata = 32'd0; I_mask = 4'd0;
    @(posedge clk); #1;
    t_ready1 = O_ready; t_rdata = O_rdata; t_int1 = O_timer_int;
  endtask

  initial begin
    logic [31:0] exp_presc;
    logic [63:0] exp64;
    logic [31:0] newlo;
    int b, rise;
`ifdef TIMER_PRESCALE_EN
    exp_presc = 32'd5;
`else
    exp_presc = 32'd0;
`endif
    vecs[0]  = '{1'b0, 3'd0, 32'd0,          4'h0, 32'd0};
    vecs[1]  = '{1'b0, 3'd1, 32'd0,          4'h0, 32'd0};
    vecs[2]  = '{1'b0, 3'd2, 32'd0,          4'h0, 32'd0};
    vecs[3]  = '{1'b0, 3'd3, 32'd0,          4'h0, 32'd0};
    vecs[4]  = '{1'b0, 3'd4, 32'd0,          4'h0, 32'hFFFF_FFFF};
    vecs[5]  = '{1'b0, 3'd5, 32'd0,          4'h0, 32'hFFFF_FFFF};
    vecs[6]  = '{1'b0, 3'd6, 32'd0,          4'h0, 32'd0};
    vecs[7]  = '{1'b1, 3'd4, 32'h1234_5678,  4'hF, 32'd0};
    vecs[8]  = '{1'b0, 3'd4, 32'd0,          4'h0, 32'h1234_5678};
    vecs[9]  = '{1'b1, 3'd5, 32'hAABB_CCDD,  4'h5, 32'd0};
    vecs[10] = '{1'b0, 3'd5, 32'd0,          4'h0, 32'hFFBB_FFDD};
    vecs[11] = '{1'b1, 3'd7, 32'hDEAD_BEEF,  4'hF, 32'd0};
    vecs[12] = '{1'b0, 3'd7, 32'd0,          4'h0, 32'd0};
    vecs[13] = '{1'b1, 3'd1, 32'h0000_0005,  4'h3, 32'd0};
    vecs[14] = '{1'b0, 3'd1, 32'd0,          4'h0, exp_presc};
    vecs[15] = '{1'b1, 3'd2, 32'h1122_3344,  4'hF, 32'd0};
    vecs[16] = '{1'b0, 3'd2, 32'd0,          4'h0, 32'h1122_3344};
    vecs[17] = '{1'b0, 3'd3, 32'd0,          4'h0, 32'd0};
    vecs[18] = '{1'b1, 3'd0, 32'hFFFF_FFFF,  4'hE, 32'd0};
    vecs[19] = '{1'b0, 3'd0, 32'd0,          4'h0, 32'd0};
    vecs[20] = '{1'b1, 3'd0, 32'h0000_0002,  4'h1, 32'd0};
    vecs[21] = '{1'b0, 3'd0, 32'd0,          4'h0, 32'd2};

    // Outputs held at reset values while rst is low
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", {63'd0, O_ready}, 64'd0);
    check("reset_rdata", {32'd0, O_rdata}, 64'd0);
    check("reset_int",   {63'd0, O_timer_int}, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 22; i++) begin
      xact(vecs[i].we, vecs[i].off, vecs[i].wdata, vecs[i].mask);
      check($sformatf("vec%0d_early_ready", i), {63'd0, t_ready0}, 64'd0);
      check($sformatf("vec%0d_ready", i), {63'd0, t_ready1}, 64'd1);
      check($sformatf("vec%0d_rdata", i), {32'd0, t_rdata}, {32'd0, vecs[i].exp});
      check($sformatf("vec%0d_int", i), {63'd0, t_int1}, 64'd0);
    end

    // Back-to-back reads
    @(negedge clk);
    I_req = 1'b1; I_we = 1'b0; I_addr = 32'h0200_0010;
    @(posedge clk);
    @(negedge clk);
    I_addr = 32'h0200_0000;
    @(posedge clk); #1;
    check("b2b_ready0", {63'd0, O_ready}, 64'd1);
    check("b2b_rdata0", {32'd0, O_rdata}, 64'h1234_5678);
    @(negedge clk);
    I_req = 1'b0;
    @(posedge clk); #1;
    check("b2b_ready1", {63'd0, O_ready}, 64'd1);
    check("b2b_rdata1", {32'd0, O_rdata}, 64'd2);
    @(posedge clk); #1;
    check("b2b_idle_ready", {63'd0, O_ready}, 64'd0);
    check("b2b_idle_rdata", {32'd0, O_rdata}, 64'd0);

    // Counting from enable
    do_reset();
`ifdef TIMER_PRESCALE_EN
    xact(1'b1, 3'd1, 32'd3, 4'hF);
`endif
    xact(1'b1, 3'd0, 32'd1, 4'hF);
    b = t_edge;
    repeat (8) @(posedge clk);
    xact(1'b0, 3'd2, 32'd0, 4'h0);
`ifdef TIMER_PRESCALE_EN
    check("count_lo", {32'd0, t_rdata}, 64'((t_edge - b - 1) / 4));
`else
    check("count_lo", {32'd0, t_rdata}, 64'(t_edge - b - 1));
`endif

    // LO wrap, carry into HI, shadowed HI read
    do_reset();
    xact(1'b1, 3'd2, 32'hFFFF_FFFD, 4'hF);
    xact(1'b1, 3'd0, 32'd1, 4'hF);
    b = t_edge;
    for (int k = 0; k < 2; k++) begin
      xact(1'b0, 3'd2, 32'd0, 4'h0);
      exp64 = 64'hFFFF_FFFD + 64'(t_edge - b - 1);
      check($sformatf("wrap_lo%0d", k), {32'd0, t_rdata}, {32'd0, exp64[31:0]});
      xact(1'b0, 3'd3, 32'd0, 4'h0);
      check($sformatf("wrap_hi%0d", k), {32'd0, t_rdata}, {32'd0, exp64[63:32]});
    end
    check("wrap_hi_final", exp64[63:32], 64'd1);

    // Interrupt rise at mtime == 100, then the two clear paths
    do_reset();
    xact(1'b1, 3'd5, 32'd0, 4'hF);
    xact(1'b1, 3'd4, 32'd100, 4'hF);
    xact(1'b1, 3'd0, 32'd3, 4'hF);
    b = t_edge;
    rise = -1;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (O_timer_int) begin
        rise = cyc;
        break;
      end
    end
    check("int_rise_edge", 64'(rise - b), 64'd101);
    xact(1'b1, 3'd4, 32'd1000, 4'hF);
    check("int_cmp_raise_hold", {63'd0, t_int0}, 64'd1);
    check("int_cmp_raise_drop", {63'd0, t_int1}, 64'd0);
    xact(1'b1, 3'd4, 32'd50, 4'hF);
    check("int_cmp_lower_pre", {63'd0, t_int0}, 64'd0);
    check("int_cmp_lower_rise", {63'd0, t_int1}, 64'd1);
    xact(1'b1, 3'd0, 32'd1, 4'hF);
    check("int_ie_clear_hold", {63'd0, t_int0}, 64'd1);
    check("int_ie_clear_drop", {63'd0, t_int1}, 64'd0);

    // Masked mtime write colliding with a tick
    do_reset();
    xact(1'b1, 3'd0, 32'd1, 4'hF);
    b = t_edge;
    xact(1'b1, 3'd2, 32'h0000_AB00, 4'b0010);
    newlo = (32'(t_edge - b - 1) & 32'hFFFF_00FF) | 32'h0000_AB00;
    b = t_edge;
    xact(1'b0, 3'd2, 32'd0, 4'h0);
    check("mask_lo", {32'd0, t_rdata}, {32'd0, newlo + 32'(t_edge - b - 1)});
    xact(1'b0, 3'd3, 32'd0, 4'h0);
    check("mask_hi", {32'd0, t_rdata}, 64'd0);

    // Reset between a request and its response
    do_reset();
    xact(1'b1, 3'd5, 32'd0, 4'hF);
    xact(1'b1, 3'd4, 32'd0, 4'hF);
    xact(1'b1, 3'd0, 32'd3, 4'hF);
    check("pre_rst_int", {63'd0, t_int1}, 64'd1);
    @(negedge clk);
    I_req = 1'b1; I_we = 1'b0; I_addr = 32'h0200_0010;
    @(posedge clk);
    @(negedge clk);
    I_req = 1'b0;
    rst = 1'b0;
    #1;
    check("midrst_ready", {63'd0, O_ready}, 64'd0);
    check("midrst_rdata", {32'd0, O_rdata}, 64'd0);
    check("midrst_int", {63'd0, O_timer_int}, 64'd0);
    @(posedge clk); #1;
    check("midrst_no_resp", {63'd0, O_ready}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    xact(1'b0, 3'd4, 32'd0, 4'h0);
    check("post_rst_cmp_lo", {32'd0, t_rdata}, 64'hFFFF_FFFF);
    xact(1'b0, 3'd5, 32'd0, 4'h0);
    check("post_rst_cmp_hi", {32'd0, t_rdata}, 64'hFFFF_FFFF);
    xact(1'b0, 3'd0, 32'd0, 4'h0);
    check("post_rst_ctrl", {32'd0, t_rdata}, 64'd0);
    xact(1'b0, 3'd2, 32'd0, 4'h0);
    check("post_rst_mtime_lo", {32'd0, t_rdata}, 64'd0);
    check("post_rst_int", {63'd0, t_int1}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
